control_stage: RTL and testbench
================================

CONTROL_STAGE -- requirements
Module: control_stage

Interface
REQ-001 Parameter EXT_EN, default 1, enables the JAL (1101111), JALR (1100111) and LUI (0110111) decodes; when 0 these opcodes are illegal.
REQ-002 Parameter CNT_W, default 8, sets the width of the illegal-opcode counter.
REQ-003 Parameter RA_W, default 5, sets the register-address width.
REQ-004 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 valid_i  in  1  the ID stage holds a real instruction.
REQ-007 Op_i  in  7  opcode of the ID instruction.
REQ-008 rs1_i, rs2_i, rd_i  in  RA_W each  source and destination register addresses of the ID instruction.
REQ-009 hold_i  in  1  external freeze; the ID/EX register keeps its contents.
REQ-010 flush_i  in  1  branch taken; the ID/EX register loads a bubble.
REQ-011 RegWrite_o, MemReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o, Jump_o  out  1 each  registered EX-stage controls.
REQ-012 ALUOp_o  out  2  registered EX-stage ALU operation class.
REQ-013 valid_o  out  1  the EX stage holds a real instruction.
REQ-014 rd_o  out  RA_W  registered EX-stage destination register.
REQ-015 stall_o  out  1  combinational load-use stall request to the PC and IF/ID registers.
REQ-016 illegal_o  out  1  sticky illegal-opcode flag.
REQ-017 illegal_cnt_o  out  CNT_W  illegal-opcode count.

Function
REQ-018 Decode as {RegWrite,MemReg,MemRead,MemWrite,ALUSrc,Branch,Jump,ALUOp}:
- R 0110011 -> 1,0,0,0,0,0,0,10
- I 0010011 -> 1,0,0,0,1,0,0,11
- load 0000011 -> 1,1,1,0,1,0,0,00
- store 0100011 -> 0,0,0,1,1,0,0,00
- beq 1100011 -> 0,0,0,0,0,1,0,01
- JAL/JALR -> 1,0,0,0,1,0,1,00
- LUI -> 1,0,0,0,1,0,0,00
REQ-019 Opcode 0000000, any illegal opcode, or valid_i=0 decodes to a bubble: all controls 0, ALUOp 00, valid_o 0.
REQ-020 The decode is fully specified for every opcode value; no latched state is inferred.
REQ-021 stall_o = valid_i & valid_o & MemRead_o & (rd_o != 0) & (rd_o == rs1_i | rd_o == rs2_i) & !flush_i.
REQ-022 The ID/EX register updates each cycle with priority rst_i > flush_i > hold_i > stall_o > normal load.
- flush_i: load a bubble.
- hold_i: keep the current contents; stall_o is still evaluated.
- stall_o: load a bubble; rd_o = 0.
- normal load: load the decode of REQ-018/019 and rd_i; latency is one cycle from Op_i to the outputs.
REQ-023 An illegal-opcode event is valid_i=1 with an illegal opcode on a normal-load cycle; held, flushed and stalled cycles are not counted.
REQ-024 Each illegal-opcode event sets illegal_o and increments illegal_cnt_o; the counter saturates at all-ones and does not wrap.
REQ-025 illegal_o and illegal_cnt_o clear only on rst_i.

Reset
REQ-026 When rst_i=1 at a clock edge, every registered output becomes 0 (controls, ALUOp_o, valid_o, rd_o, illegal_o, illegal_cnt_o), overriding all other inputs.
REQ-027 A reset issued mid-stall takes effect on that edge; with valid_o=0, stall_o then reads 0 combinationally.

Verification
REQ-028 Opcodes R, I, load, store, beq, JAL, LUI applied back-to-back with valid_i=1 -> each REQ-018 vector appears one cycle later with valid_o=1.
REQ-029 Load writing x5, then an R-type with rs1=5 -> stall_o=1 for one cycle, a bubble in EX, then the R-type decode; the same sequence with rd=0 -> no stall.
REQ-030 flush_i together with a load-use hazard -> stall_o=0 and a bubble is loaded; hold_i=1 for 3 cycles -> outputs unchanged.
REQ-031 EXT_EN=0 with JAL applied -> bubble, illegal_o=1, illegal_cnt_o=1; with CNT_W=2, five illegal events -> count stays at 3.
REQ-032 rst_i asserted mid-stream with illegal_cnt_o=2 -> all outputs 0 on the next edge; opcode 0000000 -> bubble and no count.

Source files
------------

// File: rtl/control_stage.sv
// Purpose : ID-stage control decode feeding the ID/EX pipeline register, with load-use stall and illegal-opcode tracking.
// Latency : one cycle from Op_i/rd_i to the registered EX-stage outputs; stall_o is combinational.
// Backpressure: hold_i freezes ID/EX, flush_i and stall_o load a bubble; stall_o asks PC/IF-ID to freeze.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   valid_i, Op_i              ID instruction present and its opcode
//   rs1_i, rs2_i, rd_i         ID source/destination register addresses
//   hold_i, flush_i            freeze ID/EX, or load a bubble (taken branch)
//   RegWrite_o .. ALUOp_o      registered EX-stage controls
//   valid_o, rd_o              EX instruction present and its destination
//   stall_o                    load-use stall request
//   illegal_o, illegal_cnt_o   sticky illegal-opcode flag and saturating count
module control_stage #(
    parameter int EXT_EN = 1,
    parameter int CNT_W  = 8,
    parameter int RA_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [6:0]       Op_i,
    input  logic [RA_W-1:0]  rs1_i,
    input  logic [RA_W-1:0]  rs2_i,
    input  logic [RA_W-1:0]  rd_i,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic             RegWrite_o,
    output logic             MemReg_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             ALUSrc_o,
    output logic             Branch_o,
    output logic             Jump_o,
    output logic [1:0]       ALUOp_o,
    output logic             valid_o,
    output logic [RA_W-1:0]  rd_o,
    output logic             stall_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [6:0] OP_NONE  = 7'b0000000;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ID/EX pipeline register
    ctrl_t             ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // decode results for the ID instruction
    ctrl_t dec_ctrl;
    logic  dec_legal;
    logic  dec_illegal;
    logic  stall;
    logic  load_en;
    logic  illegal_evt;

    // Opcode 0000000 is a deliberate no-op: it decodes to a bubble but is
    // neither legal nor counted as illegal.
    always_comb begin
        dec_ctrl    = '0;
        dec_legal   = 1'b0;
        dec_illegal = 1'b0;
        unique case (Op_i)
            OP_NONE: ;
            OP_R: begin
                dec_ctrl  = ctrl_t'(9'b1000000_10);
                dec_legal = 1'b1;
            end
            OP_I: begin
                dec_ctrl  = ctrl_t'(9'b1000100_11);
                dec_legal = 1'b1;
            end
            OP_LOAD: begin
                dec_ctrl  = ctrl_t'(9'b1110100_00);
                dec_legal = 1'b1;
            end
            OP_STORE: begin
                dec_ctrl  = ctrl_t'(9'b0001100_00);
                dec_legal = 1'b1;
            end
            OP_BEQ: begin
                dec_ctrl  = ctrl_t'(9'b0000010_01);
                dec_legal = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                if (EXT_EN != 0) begin
                    dec_ctrl  = ctrl_t'(9'b1000101_00);
                    dec_legal = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_LUI: begin
                if (EXT_EN != 0) begin
                    dec_ctrl  = ctrl_t'(9'b1000100_00);
                    dec_legal = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Load-use hazard: the EX-stage load writes a register the ID instruction
    // reads. A flush discards the ID instruction, so no stall is needed then.
    always_comb begin
        stall = valid_i & valid_q & ctrl_q.mem_read & (rd_q != '0)
              & ((rd_q == rs1_i) | (rd_q == rs2_i)) & ~flush_i;
    end

    // A normal load is the only cycle where the ID instruction enters EX,
    // and therefore the only cycle on which an illegal opcode is counted.
    always_comb begin
        load_en     = ~flush_i & ~hold_i & ~stall;
        illegal_evt = load_en & valid_i & dec_illegal;
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        rd_d    = rd_q;
        if (flush_i) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            rd_d    = '0;
        end else if (hold_i) begin
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
            rd_d    = rd_q;
        end else if (stall) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            rd_d    = '0;
        end else if (valid_i & dec_legal) begin
            ctrl_d  = dec_ctrl;
            valid_d = 1'b1;
            rd_d    = rd_i;
        end else begin
            // invalid slot, no-op or illegal opcode: bubble
            ctrl_d  = '0;
            valid_d = 1'b0;
            rd_d    = '0;
        end
    end

    always_comb begin
        illegal_d = illegal_q | illegal_evt;
        cnt_d     = cnt_q;
        if (illegal_evt && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign RegWrite_o    = ctrl_q.reg_write;
    assign MemReg_o      = ctrl_q.mem_reg;
    assign MemRead_o     = ctrl_q.mem_read;
    assign MemWrite_o    = ctrl_q.mem_write;
    assign ALUSrc_o      = ctrl_q.alu_src;
    assign Branch_o      = ctrl_q.branch;
    assign Jump_o        = ctrl_q.jump;
    assign ALUOp_o       = ctrl_q.alu_op;
    assign valid_o       = valid_q;
    assign rd_o          = rd_q;
    assign stall_o       = stall;
    assign illegal_o     = illegal_q;
    assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_control_stage.sv
// Purpose : self-checking bench for control_stage (default build plus an EXT_EN=0, CNT_W=2 build).
// Latency : checks registered outputs #1 after each rising edge, stall_o on the falling edge.
// Backpressure: exercises hold, flush, load-use stall and reset priority.
module tb_control_stage;

    localparam logic [6:0] LOAD = 7'b0000011;
    localparam logic [6:0] RTY  = 7'b0110011;
    localparam logic [6:0] ITY  = 7'b0010011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic       rst, vld, hold, flush;
    logic [6:0] op;
    logic [4:0] rs1, rs2, rd;
    logic       o_rw, o_mr, o_mrd, o_mw, o_as, o_br, o_j, o_vld, o_stall, o_ill;
    logic [1:0] o_aluop;
    logic [4:0] o_rd;
    logic [7:0] o_cnt;
    logic [8:0] o_ctrl;
    assign o_ctrl = {o_rw, o_mr, o_mrd, o_mw, o_as, o_br, o_j, o_aluop};

    control_stage dut (
        .clk_i(clk), .rst_i(rst), .valid_i(vld), .Op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .hold_i(hold), .flush_i(flush),
        .RegWrite_o(o_rw), .MemReg_o(o_mr), .MemRead_o(o_mrd), .MemWrite_o(o_mw),
        .ALUSrc_o(o_as), .Branch_o(o_br), .Jump_o(o_j), .ALUOp_o(o_aluop),
        .valid_o(o_vld), .rd_o(o_rd), .stall_o(o_stall),
        .illegal_o(o_ill), .illegal_cnt_o(o_cnt)
    );

    // EXT_EN=0, CNT_W=2 instance
    logic       rst2, vld2;
    logic [6:0] op2;
    logic [4:0] z5;
    logic       z1;
    logic       p_rw, p_mr, p_mrd, p_mw, p_as, p_br, p_j, p_vld, p_stall, p_ill;
    logic [1:0] p_aluop, p_cnt;
    logic [4:0] p_rd;
    logic [8:0] p_ctrl;
    assign p_ctrl = {p_rw, p_mr, p_mrd, p_mw, p_as, p_br, p_j, p_aluop};
    assign z5 = 5'd0;
    assign z1 = 1'b0;

    control_stage #(.EXT_EN(0), .CNT_W(2), .RA_W(5)) dut2 (
        .clk_i(clk), .rst_i(rst2), .valid_i(vld2), .Op_i(op2),
        .rs1_i(z5), .rs2_i(z5), .rd_i(z5), .hold_i(z1), .flush_i(z1),
        .RegWrite_o(p_rw), .MemReg_o(p_mr), .MemRead_o(p_mrd), .MemWrite_o(p_mw),
        .ALUSrc_o(p_as), .Branch_o(p_br), .Jump_o(p_j), .ALUOp_o(p_aluop),
        .valid_o(p_vld), .rd_o(p_rd), .stall_o(p_stall),
        .illegal_o(p_ill), .illegal_cnt_o(p_cnt)
    );

    typedef struct {
        logic [6:0] op;
        logic [8:0] ctrl;
        logic       vld;
    } vec_t;
    vec_t tbl [10];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: the first eight table rows are the legal instruction set
    function automatic logic [8:0] ref_ctrl(input logic [6:0] o);
        for (int i = 0; i < 8; i++) if (tbl[i].op == o) return tbl[i].ctrl;
        return 9'd0;
    endfunction

    function automatic bit ref_legal(input logic [6:0] o);
        for (int i = 0; i < 8; i++) if (tbl[i].op == o) return 1'b1;
        return 1'b0;
    endfunction

    // model of "what instruction sits in EX"
    bit         m_has;
    logic [6:0] m_op;
    logic [4:0] m_rd;
    bit         m_ill;
    int         m_cnt;

    initial begin
        tbl[0] = '{7'b0110011, 9'b1000000_10, 1'b1};
        tbl[1] = '{7'b0010011, 9'b1000100_11, 1'b1};
        tbl[2] = '{7'b0000011, 9'b1110100_00, 1'b1};
        tbl[3] = '{7'b0100011, 9'b0001100_00, 1'b1};
        tbl[4] = '{7'b1100011, 9'b0000010_01, 1'b1};
        tbl[5] = '{7'b1101111, 9'b1000101_00, 1'b1};
        tbl[6] = '{7'b1100111, 9'b1000101_00, 1'b1};
        tbl[7] = '{7'b0110111, 9'b1000100_00, 1'b1};
        tbl[8] = '{7'b0000000, 9'b0000000_00, 1'b0};
        tbl[9] = '{7'b1111111, 9'b0000000_00, 1'b0};

        rst = 1; vld = 0; op = 0; rs1 = 0; rs2 = 0; rd = 0; hold = 0; flush = 0;
        rst2 = 1; vld2 = 0; op2 = 0;
        tick(); tick();

        // reset state
        chk("rst_ctrl", 32'(o_ctrl), 0);
        chk("rst_vld", 32'(o_vld), 0);
        chk("rst_rd", 32'(o_rd), 0);
        chk("rst_ill", 32'(o_ill), 0);
        chk("rst_cnt", 32'(o_cnt), 0);
        chk("rst_stall", 32'(o_stall), 0);
        rst = 0; rst2 = 0;

        // back-to-back decode table
        for (int k = 0; k < 10; k++) begin
            vld = 1; op = tbl[k].op; rd = 5'(k + 1); rs1 = 0; rs2 = 0;
            tick();
            chk($sformatf("tbl%0d_ctrl", k), 32'(o_ctrl), 32'(tbl[k].ctrl));
            chk($sformatf("tbl%0d_vld", k), 32'(o_vld), 32'(tbl[k].vld));
            if (tbl[k].vld) chk($sformatf("tbl%0d_rd", k), 32'(o_rd), 32'(k + 1));
        end
        chk("tbl_cnt", 32'(o_cnt), 1);
        chk("tbl_ill", 32'(o_ill), 1);

        // load-use: load x5 then R-type reading x5
        op = LOAD; rd = 5; rs1 = 0; rs2 = 0; tick();
        op = RTY; rs1 = 5; rd = 7;
        @(negedge clk); chk("lu_stall", 32'(o_stall), 1);
        tick();
        chk("lu_bub_ctrl", 32'(o_ctrl), 0);
        chk("lu_bub_vld", 32'(o_vld), 0);
        chk("lu_bub_rd", 32'(o_rd), 0);
        @(negedge clk); chk("lu_stall_drop", 32'(o_stall), 0);
        tick();
        chk("lu_r_ctrl", 32'(o_ctrl), 32'(tbl[0].ctrl));
        chk("lu_r_rd", 32'(o_rd), 7);
        // rd=0 load: no stall
        op = LOAD; rd = 0; rs1 = 0; tick();
        op = RTY; rs1 = 0; rd = 7;
        @(negedge clk); chk("lu0_stall", 32'(o_stall), 0);
        tick();
        chk("lu0_r_ctrl", 32'(o_ctrl), 32'(tbl[0].ctrl));
        // hazard through rs2
        op = LOAD; rd = 6; rs1 = 0; tick();
        op = RTY; rs1 = 1; rs2 = 6; rd = 7;
        @(negedge clk); chk("lu_rs2_stall", 32'(o_stall), 1);
        tick(); rs2 = 0;

        // flush with hazard present
        op = LOAD; rd = 5; rs1 = 0; tick();
        op = RTY; rs1 = 5; rd = 7; flush = 1;
        @(negedge clk); chk("fl_stall", 32'(o_stall), 0);
        tick();
        chk("fl_vld", 32'(o_vld), 0);
        chk("fl_ctrl", 32'(o_ctrl), 0);
        op = BAD; tick();
        chk("fl_nocount", 32'(o_cnt), 1);
        flush = 0;

        // hold for three cycles with an illegal opcode waiting
        op = ITY; rd = 9; rs1 = 0; tick();
        hold = 1; op = BAD;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold%0d_ctrl", k), 32'(o_ctrl), 32'(tbl[1].ctrl));
            chk($sformatf("hold%0d_rd", k), 32'(o_rd), 9);
            chk($sformatf("hold%0d_cnt", k), 32'(o_cnt), 1);
        end
        // hold wins over stall, but stall_o still reports
        hold = 0; op = LOAD; rd = 5; tick();
        hold = 1; op = RTY; rs1 = 5; rd = 7;
        @(negedge clk); chk("hs_stall", 32'(o_stall), 1);
        tick();
        chk("hs_ctrl", 32'(o_ctrl), 32'(tbl[2].ctrl));
        chk("hs_rd", 32'(o_rd), 5);
        hold = 0; tick();
        chk("hs_bub", 32'(o_vld), 0);
        tick();
        chk("hs_r", 32'(o_ctrl), 32'(tbl[0].ctrl));

        // EXT_EN=0, CNT_W=2 instance: extension opcodes illegal, count saturates
        begin
            logic [6:0] seq [5];
            seq[0] = JAL; seq[1] = JALR; seq[2] = LUI; seq[3] = BAD; seq[4] = JAL;
            vld2 = 1;
            for (int k = 0; k < 5; k++) begin
                op2 = seq[k];
                tick();
                chk($sformatf("ext%0d_vld", k), 32'(p_vld), 0);
                chk($sformatf("ext%0d_ctrl", k), 32'(p_ctrl), 0);
                chk($sformatf("ext%0d_ill", k), 32'(p_ill), 1);
                chk($sformatf("ext%0d_cnt", k), 32'(p_cnt), (k + 1 > 3) ? 3 : k + 1);
            end
            vld2 = 0;
        end

        // reset mid-stall with count 2
        rst = 1; rs1 = 0; tick(); rst = 0;
        op = BAD; tick(); tick();
        chk("pre_rst_cnt", 32'(o_cnt), 2);
        op = LOAD; rd = 5; tick();
        op = RTY; rs1 = 5; rd = 7;
        @(negedge clk); chk("mid_stall", 32'(o_stall), 1);
        rst = 1; tick();
        chk("mr_ctrl", 32'(o_ctrl), 0);
        chk("mr_vld", 32'(o_vld), 0);
        chk("mr_rd", 32'(o_rd), 0);
        chk("mr_ill", 32'(o_ill), 0);
        chk("mr_cnt", 32'(o_cnt), 0);
        chk("mr_stall", 32'(o_stall), 0);
        rst = 0; op = 7'b0000000; rs1 = 0; tick();
        chk("nop_vld", 32'(o_vld), 0);
        chk("nop_ctrl", 32'(o_ctrl), 0);
        chk("nop_ill", 32'(o_ill), 0);
        chk("nop_cnt", 32'(o_cnt), 0);

        // randomized run against the reference model
        rst = 1; tick(); rst = 0;
        m_has = 0; m_op = 0; m_rd = 0; m_ill = 0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            bit exp_stall;
            int sel;
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            vld   = ($urandom_range(0, 4) != 0);
            sel   = $urandom_range(0, 10);
            if (sel < 8)       op = tbl[sel].op;
            else if (sel == 8) op = 7'b0000000;
            else               op = 7'($urandom);
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));

            exp_stall = vld && m_has && (m_op == LOAD) && (m_rd != 0)
                        && (m_rd == rs1 || m_rd == rs2) && !flush;
            @(negedge clk);
            chk($sformatf("rnd%0d_stall", n), 32'(o_stall), 32'(exp_stall));

            if (rst) begin
                m_has = 0; m_ill = 0; m_cnt = 0;
            end else if (flush) begin
                m_has = 0;
            end else if (hold) begin
                // EX keeps its instruction
            end else if (exp_stall) begin
                m_has = 0;
            end else begin
                m_has = vld && ref_legal(op);
                m_op  = op;
                m_rd  = rd;
                if (vld && !ref_legal(op) && op != 7'b0000000) begin
                    m_ill = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            tick();
            chk($sformatf("rnd%0d_ctrl", n), 32'(o_ctrl), m_has ? 32'(ref_ctrl(m_op)) : 0);
            chk($sformatf("rnd%0d_vld", n), 32'(o_vld), 32'(m_has));
            if (m_has) chk($sformatf("rnd%0d_rd", n), 32'(o_rd), 32'(m_rd));
            chk($sformatf("rnd%0d_ill", n), 32'(o_ill), 32'(m_ill));
            chk($sformatf("rnd%0d_cnt", n), 32'(o_cnt), 32'(m_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
